// File: rtl/remote_msg_receiver.sv
// Receive side of the interboard move/turn link: queues peer messages and replays them as
// serialized map cell writes, opponent hand-count updates and a turn hand-over pulse.
module remote_msg_receiver #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [5:0]  EMPTY_CARD = 6'd54,
    parameter logic [6:0]  MAX_CARDS  = 7'd106
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       interboard_en,
    input  logic [3:0] interboard_msg_type,
    input  logic       interboard_move_dir,
    input  logic [4:0] interboard_block_x,
    input  logic [2:0] interboard_block_y,
    input  logic [5:0] interboard_card,
    input  logic [2:0] interboard_sel_len,
    output logic       map_wr_en,
    output logic [4:0] map_wr_x,
    output logic [2:0] map_wr_y,
    output logic [5:0] map_wr_card,
    output logic [6:0] opp_card_cnt,
    output logic       switch_turn_remote,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned EntW = 22;
    localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

    localparam logic [3:0] TypeNop   = 4'd0;
    localparam logic [3:0] TypeDraw  = 4'd1;
    localparam logic [3:0] TypePlace = 4'd2;
    localparam logic [3:0] TypeClear = 4'd3;
    localparam logic [3:0] TypeTurn  = 4'd4;
    localparam logic [5:0] LastCol   = 6'd17;

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StTurn} state_e;

    logic clr;
    assign clr = rst | interboard_rst;

    // Message FIFO
    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   fcnt_q, fcnt_d;
    logic            full, empty, msg_valid, push, pop, overflow;
    logic [EntW-1:0] head, entry;

    state_e state_q, state_d;

    assign full      = (fcnt_q == FullCnt);
    assign empty     = (fcnt_q == '0);
    assign pop       = (state_q == StIdle) && !empty;
    assign msg_valid = interboard_en && (interboard_msg_type != TypeNop);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = msg_valid && (!full || pop);
    assign overflow  = msg_valid && full && !pop;
    assign head      = mem_q[rptr_q];
    assign entry     = {interboard_msg_type, interboard_move_dir, interboard_block_x,
                        interboard_block_y, interboard_card, interboard_sel_len};

    always_comb begin
        fcnt_d = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            fcnt_q <= fcnt_d;
        end
    end

    // Command registers and execution state
    logic [3:0] cmd_type_q;
    logic       cmd_dir_q;
    logic [2:0] cmd_y_q;
    logic [5:0] cmd_card_q;
    logic [2:0] cmd_len_q;
    logic [5:0] x_q, x_d;
    logic [2:0] rem_q, rem_d;
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_comb begin
        state_d            = state_q;
        x_d                = x_q;
        rem_d              = rem_q;
        cnt_d              = cnt_q;
        err_d              = err_q | overflow;
        map_wr_en          = 1'b0;
        map_wr_x           = '0;
        map_wr_y           = '0;
        map_wr_card        = '0;
        switch_turn_remote = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    x_d     = {1'b0, head[16:12]};
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StIdle;
                case (cmd_type_q)
                    TypeDraw: begin
                        if (cnt_q < MAX_CARDS) cnt_d = cnt_q + 7'd1;
                    end
                    TypePlace: begin
                        rem_d   = 3'd1;
                        state_d = StExec;
                    end
                    TypeClear: begin
                        rem_d   = (cmd_len_q == 3'd0) ? 3'd1 : cmd_len_q;
                        state_d = StExec;
                    end
                    TypeTurn: state_d = StTurn;
                    default:  err_d   = 1'b1;
                endcase
            end
            StExec: begin
                // A run that walks off the right edge is cut short at the edge.
                if (x_q > LastCol) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    map_wr_en   = 1'b1;
                    map_wr_x    = x_q[4:0];
                    map_wr_y    = cmd_y_q;
                    map_wr_card = (cmd_type_q == TypeClear) ? EMPTY_CARD : cmd_card_q;
                    if (cmd_type_q == TypePlace && !cmd_dir_q) begin
                        if (cnt_q == 7'd0) err_d = 1'b1;
                        else               cnt_d = cnt_q - 7'd1;
                    end
                    if (rem_q == 3'd1) begin
                        state_d = StIdle;
                    end else begin
                        rem_d = rem_q - 3'd1;
                        x_d   = x_q + 6'd1;
                    end
                end
            end
            StTurn: begin
                switch_turn_remote = 1'b1;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            x_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            cmd_type_q <= '0;
            cmd_dir_q  <= 1'b0;
            cmd_y_q    <= '0;
            cmd_card_q <= '0;
            cmd_len_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (pop) begin
                cmd_type_q <= head[21:18];
                cmd_dir_q  <= head[17];
                cmd_y_q    <= head[11:9];
                cmd_card_q <= head[8:3];
                cmd_len_q  <= head[2:0];
            end
        end
    end

    assign opp_card_cnt = cnt_q;
    assign err          = err_q;
    assign busy         = !empty || (state_q != StIdle);

endmodule
